fc_feeder: RTL and testbench
============================

FC_FEEDER -- requirements
Module: fc_feeder

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12, meaning the signed width of each lane.
REQ-002 SHALL have parameter BEATS, default 16, meaning the data beats per frame per lane.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 valid_in  input  1  upstream beat strobe, one value per lane per beat.
REQ-006 data_in_1, data_in_2, data_in_3  input  DATA_BITS each  signed channel 1/2/3 values.
REQ-007 in_ready  output  1  high when a free bank can accept a beat.
REQ-008 overflow  output  1  one-cycle pulse when a beat is dropped.
REQ-009 fc_busy  input  1  downstream FC layer busy flag.
REQ-010 valid_out  output  1  downstream beat strobe.
REQ-011 data_out_1, data_out_2, data_out_3  output  DATA_BITS each  lane values to the FC layer.
REQ-012 busy  output  1  high when any bank is full or the FSM is not IDLE.

Function
REQ-013 SHALL hold two banks; each bank holds 3 x BEATS values.
REQ-014 Write side: wr_bank pointer and wr_idx counter (0..BEATS-1); an accepted beat stores lane k at bank[wr_bank][k][wr_idx].
REQ-015 A beat is accepted when valid_in=1 and bank_full[wr_bank]=0; in_ready = !bank_full[wr_bank].
REQ-016 When valid_in=1 and bank_full[wr_bank]=1, the beat is dropped and overflow=1 on the next cycle; storage and counters are unchanged.
REQ-017 On accepting the beat with wr_idx=BEATS-1: set bank_full[wr_bank], wr_idx wraps to 0, wr_bank toggles.
REQ-018 Read FSM states: IDLE, START, SEND, DRAIN; all outputs are registered.
REQ-019 IDLE -> START when bank_full[rd_bank]=1 and fc_busy=0; in START, valid_out=1 and all data_out=0 (frame-start beat, data ignored downstream).
REQ-020 START -> SEND unconditionally; SEND emits BEATS consecutive beats, valid_out=1, beat j carries bank[rd_bank][lane][j], j=0..BEATS-1.
REQ-021 After beat BEATS-1: clear bank_full[rd_bank], toggle rd_bank, enter DRAIN; valid_out=0.
REQ-022 DRAIN -> IDLE when fc_busy=0; fc_busy is ignored during START and SEND.
REQ-023 A burst is never paused; a frame is always BEATS+1 contiguous valid_out cycles.
REQ-024 Latency: the start beat is driven on the second rising edge after the last input beat is sampled, if the FSM is IDLE and fc_busy=0.
REQ-025 If a fill-complete and a bank-clear hit the same cycle on different banks, both SHALL take effect.
REQ-026 A read of a bank and a write to the same bank never occur together, because full banks are not writable.
REQ-027 data_out holds its last value when valid_out=0 (SEND->DRAIN data is don't-care but stable).
REQ-028 Values pass unmodified; there is no sign extension or rounding.

Reset
REQ-029 rst=1 SHALL, on the next edge, force: state IDLE, wr_idx=0, wr_bank=0, rd_bank=0, bank_full=00, valid_out=0, data_out_*=0, overflow=0, busy=0; in_ready=1 after the reset edge.
REQ-030 Reset mid-fill or mid-burst SHALL discard all buffered frames; no partial burst resumes.
REQ-031 Bank contents are not reset.

Verification
REQ-032 Single frame: 16 beats, lane1=j, lane2=100+j, lane3=-j, fc_busy=0 -> start beat zeros, then 16 beats matching in order; valid_out high exactly 17 cycles.
REQ-033 Back-to-back frames: 32 continuous beats while fc_busy is held high for 40 cycles after each start beat -> in_ready stays 1 for all 32 beats; second frame is sent only after fc_busy falls.
REQ-034 Overflow: 3 frames sent with fc_busy stuck 1 -> beats 33..48 dropped, overflow pulses 16 times, in_ready=0; releasing fc_busy sends frame 1 then frame 2 intact.
REQ-035 Busy gating: bank full while fc_busy=1 -> no valid_out; fc_busy falls at cycle N -> start beat at N+1.
REQ-036 Reset mid-burst: rst at beat 8 -> valid_out=0 next cycle, busy=0, in_ready=1; a new frame afterward is sent correctly from bank 0.
REQ-037 Signed extremes: lane values 0x7FF and 0x800 -> emitted bit-exact.

Source files
------------

// File: rtl/fc_feeder.sv
// Double-banked frame buffer between a 3-lane sample source and an FC layer.
// Each filled bank is replayed as one zero start beat plus BEATS data beats.
module fc_feeder #(
  parameter int DATA_BITS = 12,
  parameter int BEATS     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] data_in_1,
  input  logic signed [DATA_BITS-1:0] data_in_2,
  input  logic signed [DATA_BITS-1:0] data_in_3,
  output logic                        in_ready,
  output logic                        overflow,
  input  logic                        fc_busy,
  output logic                        valid_out,
  output logic signed [DATA_BITS-1:0] data_out_1,
  output logic signed [DATA_BITS-1:0] data_out_2,
  output logic signed [DATA_BITS-1:0] data_out_3,
  output logic                        busy
);

  localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, START, SEND, DRAIN} state_t;

  // Handshake: a beat transfers on a rising edge where valid_in=1 and
  // in_ready=1; valid_in with in_ready=0 drops the beat and pulses overflow.
  // valid_out has no back-pressure: a frame is BEATS+1 contiguous beats.

  state_t                      state;
  logic [IW-1:0]               wr_idx;
  logic [RW-1:0]               rd_idx;
  logic                        wr_bank;
  logic                        rd_bank;
  logic [1:0]                  bank_full;
  logic signed [DATA_BITS-1:0] mem [2][3][BEATS];

  logic       accept;
  logic       fill_done;
  logic       clear_done;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;

  assign in_ready   = !bank_full[wr_bank];
  assign accept     = valid_in && !bank_full[wr_bank];
  assign fill_done  = accept && (wr_idx == IW'(BEATS - 1));
  assign clear_done = (state == SEND) && (rd_idx == RW'(BEATS));
  assign set_mask   = fill_done  ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask   = clear_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (|bank_full) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][0][wr_idx] <= data_in_1;
      mem[wr_bank][1][wr_idx] <= data_in_2;
      mem[wr_bank][2][wr_idx] <= data_in_3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= valid_in && bank_full[wr_bank];
      if (accept) begin
        if (fill_done) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
    end
  end

  // Fill and clear always target different banks, so both masks apply at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      valid_out  <= 1'b0;
      data_out_1 <= '0;
      data_out_2 <= '0;
      data_out_3 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bank_full[rd_bank] && !fc_busy) begin
            state      <= START;
            valid_out  <= 1'b1;
            data_out_1 <= '0;
            data_out_2 <= '0;
            data_out_3 <= '0;
          end
        end
        START: begin
          state      <= SEND;
          valid_out  <= 1'b1;
          data_out_1 <= mem[rd_bank][0][0];
          data_out_2 <= mem[rd_bank][1][0];
          data_out_3 <= mem[rd_bank][2][0];
          rd_idx     <= RW'(1);
        end
        SEND: begin
          // rd_idx counts beats already driven; reaching BEATS ends the burst.
          if (rd_idx == RW'(BEATS)) begin
            state     <= DRAIN;
            valid_out <= 1'b0;
            rd_bank   <= ~rd_bank;
            rd_idx    <= '0;
          end else begin
            data_out_1 <= mem[rd_bank][0][rd_idx[IW-1:0]];
            data_out_2 <= mem[rd_bank][1][rd_idx[IW-1:0]];
            data_out_3 <= mem[rd_bank][2][rd_idx[IW-1:0]];
            rd_idx     <= rd_idx + RW'(1);
          end
        end
        DRAIN: begin
          if (!fc_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_feeder.sv
// Directed bench for fc_feeder: frame-level queue model checked every cycle,
// plus hand-computed timing and value expectations.
module tb_fc_feeder;

  localparam int W = 12;
  localparam int B = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  logic [W-1:0] data_in_1 = '0;
  logic [W-1:0] data_in_2 = '0;
  logic [W-1:0] data_in_3 = '0;
  logic         in_ready;
  logic         overflow;
  logic         fc_busy = 1'b0;
  logic         valid_out;
  logic [W-1:0] data_out_1;
  logic [W-1:0] data_out_2;
  logic [W-1:0] data_out_3;
  logic         busy;

  fc_feeder #(.DATA_BITS(W), .BEATS(B)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .in_ready(in_ready), .overflow(overflow), .fc_busy(fc_busy),
    .valid_out(valid_out),
    .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: completed frames waiting or in flight, and the beats they must emit.
  logic [3*W-1:0] exp_q[$];
  logic [3*W-1:0] fill_q[$];
  logic [3*W-1:0] got;
  logic [3*W-1:0] last_data = '0;
  logic [3*W-1:0] e;
  int             full_frames = 0;
  int             run_len = 0;
  bit             exp_ovf = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      got = {data_out_1, data_out_2, data_out_3};
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", got, e);
        end
        run_len++;
        last_data = got;
      end else begin
        if (run_len > 0) begin
          check("frame_len", run_len, B + 1);
          full_frames--;
          run_len = 0;
        end
        check("hold_data", got, last_data);
      end
      check("in_ready", in_ready, full_frames < 2);
      check("overflow", overflow, exp_ovf);
      if (full_frames > 0 || valid_out) check("busy", busy, 1);
      // Predict the effect of the inputs sampled at the coming rising edge.
      if (rst) begin
        exp_q.delete();
        fill_q.delete();
        full_frames = 0;
        run_len = 0;
        exp_ovf = 1'b0;
        last_data = '0;
      end else begin
        exp_ovf = 1'b0;
        if (valid_in) begin
          if (full_frames < 2) begin
            fill_q.push_back({data_in_1, data_in_2, data_in_3});
            if (fill_q.size() == B) begin
              exp_q.push_back('0);
              foreach (fill_q[i]) exp_q.push_back(fill_q[i]);
              fill_q.delete();
              full_frames++;
            end
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [W-1:0] lane_val(input int kind, input int f, input int j, input int lane);
    int v;
    case (kind)
      0:       v = (lane == 1) ? j : (lane == 2) ? 100 + j : -j;
      1:       v = (lane == 1) ? f * 100 + j : (lane == 2) ? -(f * 100 + j) : 7 * j;
      default: v = (lane == 1) ? ((j % 2) ? -2048 : 2047)
                 : (lane == 2) ? ((j % 2) ? 2047 : -2048) : j;
    endcase
    return W'(v);
  endfunction

  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    @(posedge clk); #1;
    valid_in = 1'b1;
    data_in_1 = a;
    data_in_2 = b;
    data_in_3 = c;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic send_frame(input int kind, input int f);
    for (int j = 0; j < B; j++)
      drive_beat(lane_val(kind, f, j, 1), lane_val(kind, f, j, 2), lane_val(kind, f, j, 3));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !valid_out) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
  endtask

  // Wait for a start beat, then hold fc_busy high for 40 cycles.
  task automatic busy_hold(output int lat, output int vcnt);
    lat = -1;
    vcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid_out) begin
        lat = i;
        break;
      end
    end
    fc_busy = 1'b1;
    vcnt = 1;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) vcnt++;
    end
    fc_busy = 1'b0;
  endtask

  int lat1, lat2, vc1, vc2, ovf_cnt, k;
  bit seen;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_valid_out", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_overflow", overflow, 0);
    check("rst_data", {data_out_1, data_out_2, data_out_3}, 0);

    // Single frame and its latency.
    send_frame(0, 0);
    idle_cycles(1);
    check("lat_not_yet", valid_out, 0);
    @(posedge clk); #1;
    check("lat_start_valid", valid_out, 1);
    check("lat_start_zero", {data_out_1, data_out_2, data_out_3}, 0);
    repeat (6) begin @(posedge clk); #1; end
    check("beat5", {data_out_1, data_out_2, data_out_3}, {12'd5, 12'd105, 12'hFFB});
    wait_idle();

    // Fill of the second bank lands on the edge that clears the first.
    send_frame(1, 1);
    idle_cycles(2);
    send_frame(1, 2);
    idle_cycles(1);
    wait_idle();

    // Back-to-back frames with fc_busy held after each start beat.
    fork
      begin
        send_frame(1, 3);
        send_frame(1, 4);
        idle_cycles(1);
      end
      begin
        busy_hold(lat1, vc1);
        busy_hold(lat2, vc2);
      end
    join
    check("b2b_f1_seen", lat1 >= 0, 1);
    check("b2b_f1_only", vc1, 17);
    check("b2b_f2_after_fall", lat2 >= 0 && lat2 <= 2, 1);
    wait_idle();

    // Overflow with fc_busy stuck high.
    fc_busy = 1'b1;
    ovf_cnt = 0;
    fork
      begin
        send_frame(1, 5);
        send_frame(1, 6);
        send_frame(1, 7);
        idle_cycles(1);
      end
      repeat (60) begin
        @(negedge clk);
        if (overflow) ovf_cnt++;
      end
    join
    check("ovf_in_ready", in_ready, 0);
    check("ovf_count", ovf_cnt, 16);
    check("ovf_no_out", valid_out, 0);
    fc_busy = 1'b0;
    wait_idle();

    // Busy gating: start beat one cycle after fc_busy falls.
    fc_busy = 1'b1;
    send_frame(1, 8);
    idle_cycles(10);
    check("gate_held", valid_out, 0);
    fc_busy = 1'b0;
    @(negedge clk);
    check("gate_cycle_n", valid_out, 0);
    @(negedge clk);
    check("gate_cycle_n1", valid_out, 1);
    wait_idle();

    // Reset at beat 8 of a burst.
    send_frame(1, 5);
    idle_cycles(1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    check("rb_start_seen", seen, 1);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rb_valid_out", valid_out, 0);
    check("rb_busy", busy, 0);
    check("rb_in_ready", in_ready, 1);
    send_frame(1, 9);
    idle_cycles(1);
    wait_idle();

    // Signed extremes.
    send_frame(2, 0);
    idle_cycles(1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ext_lane1", data_out_1, 12'h7FF);
    check("ext_lane2", data_out_2, 12'h800);
    @(posedge clk); #1;
    check("ext_lane1_b1", data_out_1, 12'h800);
    wait_idle();

    check("leftover_beats", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
